// File: rtl/regfile_pkg.sv
// Shared register-file constants used by the register file, its read muxes
// and the write queue.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_write_queue_decoder.sv
// 5-to-32 one-hot write-enable decoder for the register file.
// The zero register is hardwired, so its enable bit is never raised.
module decoder5to32
  import regfile_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic                  i_enable,
  output logic [NUM_REGS-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_enable && (i_addr != ZERO_REG)) begin
      o_onehot[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// Buffers register write requests from slow producers and retires them one
// per cycle into the register file, with a forwarding lookup for the read path.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
)
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     cpu_wr_active,
  output logic                     wr_enable,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [NUM_REGS-1:0]      wr_onehot,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]   r_memAddr [DEPTH];
  logic [DATA_W-1:0]   r_memData [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic                r_wrEnable;
  logic [ADDR_W-1:0]   r_wrAddr;
  logic [DATA_W-1:0]   r_wrData;
  logic [NUM_REGS-1:0] r_wrOnehot;

  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_headAddr;
  logic [DATA_W-1:0]   w_headData;
  logic                w_headLive;
  logic [NUM_REGS-1:0] w_headOnehot;
  logic                w_fwdHit;
  logic [DATA_W-1:0]   w_fwdData;
  logic [PTR_W-1:0]    w_idx;

  // Full is judged on the count alone; a pop on the same edge does not open a slot.
  assign in_ready   = !reset && (r_count != CNT_W'(DEPTH));
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_count != '0) && !cpu_wr_active;
  assign w_headAddr = r_memAddr[r_head];
  assign w_headData = r_memData[r_head];
  assign w_headLive = (w_headAddr != ZERO_REG);

  decoder5to32 u_decoder (
    .i_addr   (w_headAddr),
    .i_enable (w_headLive),
    .o_onehot (w_headOnehot)
  );

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memAddr[r_tail] <= in_addr;
      r_memData[r_tail] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Address/data hold after a pop so the register file sees a stable bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrEnable <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
      r_wrOnehot <= '0;
    end else if (w_pop) begin
      r_wrEnable <= w_headLive;
      r_wrAddr   <= w_headAddr;
      r_wrData   <= w_headData;
      r_wrOnehot <= w_headOnehot;
    end else begin
      r_wrEnable <= 1'b0;
      r_wrOnehot <= '0;
    end
  end

  // Walk oldest to newest so the youngest match overrides; in-flight is oldest.
  always_comb begin
    w_fwdHit  = 1'b0;
    w_fwdData = '0;
    w_idx     = r_head;
    if (r_wrEnable && (r_wrAddr == fwd_addr)) begin
      w_fwdHit  = 1'b1;
      w_fwdData = r_wrData;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_memAddr[w_idx] == fwd_addr)) begin
        w_fwdHit  = 1'b1;
        w_fwdData = r_memData[w_idx];
      end
    end
    if (fwd_addr == ZERO_REG) begin
      w_fwdHit  = 1'b0;
      w_fwdData = '0;
    end
  end

  assign wr_enable = r_wrEnable;
  assign wr_addr   = r_wrAddr;
  assign wr_data   = r_wrData;
  assign wr_onehot = r_wrOnehot;
  assign fwd_hit   = w_fwdHit;
  assign fwd_data  = w_fwdData;
  assign count     = r_count;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: latency, stall/full, zero-register
// handling, forwarding priority, wrap-around streaming and mid-stream reset.
module tb_regfile_write_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        cpu_wr_active;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] wr_onehot;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int checkCount;
  int errorCount;

  regfile_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .cpu_wr_active (cpu_wr_active),
    .wr_enable     (wr_enable),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_onehot     (wr_onehot),
    .fwd_addr      (fwd_addr),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle push request; the caller decides whether it should be accepted.
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    in_valid = 1'b1;
    in_addr  = addr;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_addr       = '0;
    in_data       = '0;
    cpu_wr_active = 1'b0;
    fwd_addr      = '0;
    tick();
    tick();
    checkOutput("ready_in_reset", 64'(in_ready), 64'h0);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", 64'(in_ready), 64'h1);
    checkOutput("count_after_reset", 64'(count), 64'h0);
    checkOutput("wren_after_reset", 64'(wr_enable), 64'h0);
    checkOutput("onehot_after_reset", 64'(wr_onehot), 64'h0);

    // Basic latency: accept at E0, pop at E1, strobe visible E1..E2.
    fwd_addr = 5'd5;
    applyStimulus(5'd5, 32'hDEADBEEF);
    checkOutput("lat_count_e0", 64'(count), 64'h1);
    checkOutput("lat_wren_e0", 64'(wr_enable), 64'h0);
    checkOutput("lat_fwd_fifo", 64'(fwd_data), 64'hDEADBEEF);
    tick();
    checkOutput("lat_wren_e1", 64'(wr_enable), 64'h1);
    checkOutput("lat_addr_e1", 64'(wr_addr), 64'h5);
    checkOutput("lat_data_e1", 64'(wr_data), 64'hDEADBEEF);
    checkOutput("lat_onehot_e1", 64'(wr_onehot), 64'h20);
    checkOutput("lat_count_e1", 64'(count), 64'h0);
    checkOutput("lat_fwd_inflight", 64'(fwd_hit), 64'h1);
    tick();
    checkOutput("lat_wren_e2", 64'(wr_enable), 64'h0);
    checkOutput("lat_onehot_e2", 64'(wr_onehot), 64'h0);
    checkOutput("lat_addr_hold", 64'(wr_addr), 64'h5);
    checkOutput("lat_fwd_gone", 64'(fwd_hit), 64'h0);

    // Fill under stall, refuse fifth request, then drain in order.
    cpu_wr_active = 1'b1;
    for (int a = 1; a <= 4; a++) applyStimulus(5'(a), 32'h100 + 32'(a));
    checkOutput("full_count", 64'(count), 64'h4);
    checkOutput("full_ready", 64'(in_ready), 64'h0);
    applyStimulus(5'd6, 32'h106);
    checkOutput("full_refuse", 64'(count), 64'h4);
    in_valid      = 1'b1;
    in_addr       = 5'd6;
    in_data       = 32'h106;
    cpu_wr_active = 1'b0;
    #1;
    checkOutput("full_no_bypass", 64'(in_ready), 64'h0);
    tick();
    in_valid = 1'b0;
    checkOutput("drain_count_1", 64'(count), 64'h3);
    for (int a = 1; a <= 4; a++) begin
      if (a > 1) tick();
      checkOutput("drain_wren", 64'(wr_enable), 64'h1);
      checkOutput("drain_addr", 64'(wr_addr), 64'(a));
      checkOutput("drain_data", 64'(wr_data), 64'h100 + 64'(a));
    end
    checkOutput("drain_count_end", 64'(count), 64'h0);
    tick();
    checkOutput("drain_wren_off", 64'(wr_enable), 64'h0);

    // Zero-register requests are consumed without a strobe.
    fwd_addr = 5'd0;
    applyStimulus(5'd0, 32'h1234);
    checkOutput("zero_fwd_fifo", 64'(fwd_hit), 64'h0);
    applyStimulus(5'd7, 32'h77);
    checkOutput("zero_wren", 64'(wr_enable), 64'h0);
    checkOutput("zero_onehot", 64'(wr_onehot), 64'h0);
    checkOutput("zero_addr_reg", 64'(wr_addr), 64'h0);
    checkOutput("zero_count", 64'(count), 64'h1);
    checkOutput("zero_fwd_hit", 64'(fwd_hit), 64'h0);
    tick();
    checkOutput("r7_wren", 64'(wr_enable), 64'h1);
    checkOutput("r7_addr", 64'(wr_addr), 64'h7);
    checkOutput("r7_onehot", 64'(wr_onehot), 64'h80);
    checkOutput("r7_fwd_zero", 64'(fwd_data), 64'h0);
    tick();
    checkOutput("r7_wren_off", 64'(wr_enable), 64'h0);

    // Forwarding: youngest match wins, same-cycle accept is invisible.
    fwd_addr      = 5'd9;
    cpu_wr_active = 1'b1;
    in_valid      = 1'b1;
    in_addr       = 5'd9;
    in_data       = 32'hA;
    #1;
    checkOutput("fwd_same_cycle", 64'(fwd_hit), 64'h0);
    tick();
    in_valid = 1'b0;
    checkOutput("fwd_first", 64'(fwd_data), 64'hA);
    applyStimulus(5'd9, 32'hB);
    checkOutput("fwd_young_hit", 64'(fwd_hit), 64'h1);
    checkOutput("fwd_young_data", 64'(fwd_data), 64'hB);
    cpu_wr_active = 1'b0;
    tick();
    checkOutput("fwd_fifo_over_flight", 64'(fwd_data), 64'hB);
    tick();
    checkOutput("fwd_flight_data", 64'(fwd_data), 64'hB);
    checkOutput("fwd_flight_hit", 64'(fwd_hit), 64'h1);
    tick();
    checkOutput("fwd_cleared_hit", 64'(fwd_hit), 64'h0);
    checkOutput("fwd_cleared_data", 64'(fwd_data), 64'h0);

    // Streaming push+pop every edge across several pointer wraps.
    in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_addr = 5'(k + 1);
      in_data = 32'h5000 + 32'(k);
      tick();
      checkOutput("stream_count", 64'(count), 64'h1);
      if (k > 0) begin
        checkOutput("stream_wren", 64'(wr_enable), 64'h1);
        checkOutput("stream_data", 64'(wr_data), 64'h5000 + 64'(k - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    checkOutput("stream_last_data", 64'(wr_data), 64'h500B);
    checkOutput("stream_last_addr", 64'(wr_addr), 64'hC);
    checkOutput("stream_empty", 64'(count), 64'h0);
    tick();
    checkOutput("stream_wren_off", 64'(wr_enable), 64'h0);

    // Mid-stream reset discards everything buffered.
    cpu_wr_active = 1'b1;
    applyStimulus(5'd10, 32'hA0);
    applyStimulus(5'd11, 32'hB0);
    applyStimulus(5'd12, 32'hC0);
    checkOutput("pre_reset_count", 64'(count), 64'h3);
    reset = 1'b1;
    #1;
    checkOutput("reset_ready_low", 64'(in_ready), 64'h0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("post_reset_count", 64'(count), 64'h0);
    checkOutput("post_reset_wren", 64'(wr_enable), 64'h0);
    checkOutput("post_reset_ready", 64'(in_ready), 64'h1);
    checkOutput("post_reset_addr", 64'(wr_addr), 64'h0);
    cpu_wr_active = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("no_stale_wren", 64'(wr_enable), 64'h0);
      checkOutput("no_stale_count", 64'(count), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
